// File: rtl/lfsr_rng_pkg.sv
// Shared types and helpers for the ranged LFSR random source.
// Holds the FSM state enum, default tap masks and the range test.
package lfsr_rng_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } rng_state_e;

    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h80200003;

    function automatic logic in_range(
        input logic [31:0] cand,
        input logic [31:0] max
    );
        return (cand != 32'd0) && (cand <= max);
    endfunction

endpackage

// File: rtl/lfsr_rng_if.sv
// Valid/ready bundle carrying an accepted random sample.
// The producer drives valid/value; the consumer drives ready.
interface lfsr_rng_if #(
    parameter int OUT_W = 4
);
    logic             rnd_valid;
    logic             rnd_ready;
    logic [OUT_W-1:0] rnd_value;

    modport master (
        output rnd_valid,
        output rnd_value,
        input  rnd_ready
    );

    modport slave (
        input  rnd_valid,
        input  rnd_value,
        output rnd_ready
    );
endinterface

// File: rtl/lfsr_rng_ranged_core.sv
// Fibonacci LFSR register with seed load and a period counter.
// A wrap pulse marks the step that brings the sequence back to its seed.
module lfsr_core #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 'hB8,
    parameter logic [WIDTH-1:0] SEED  = 'hAC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] period,
    output logic             period_wrap
);

    localparam logic [WIDTH-1:0] PMAX = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q, wrap_d;

    // Next state: load wins over step; a zero seed falls back to SEED.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        if (load) begin
            state_d  = (seed_in == '0) ? SEED : seed_in;
            period_d = '0;
        end else if (step) begin
            state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
            if (period_q == PMAX) begin
                period_d = '0;
                wrap_d   = 1'b1;
            end else begin
                period_d = period_q + ONE;
            end
        end
    end

    // State, period and wrap registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEED;
            period_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
        end
    end

    assign state       = state_q;
    assign period      = period_q;
    assign period_wrap = wrap_q;

endmodule

// File: rtl/lfsr_rng_ranged.sv
// Range-limited random source: LFSR candidates in 1..RANGE_MAX are kept,
// others rejected, and kept values are offered on a valid/ready bundle.
module lfsr_rng_ranged
    import lfsr_rng_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 'hB8,
    parameter logic [WIDTH-1:0] SEED      = 'hAC,
    parameter int               OUT_W     = 4,
    parameter int               RANGE_MAX = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    lfsr_rng_if.master       rng,
    output logic [WIDTH-1:0] lfsr_state,
    output logic [WIDTH-1:0] period,
    output logic             period_wrap
);

    rng_state_e       fsm_q, fsm_d;
    logic [OUT_W-1:0] value_q, value_d;
    logic [OUT_W-1:0] cand;
    logic             accept;
    logic             take;
    logic             hs;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .step        (en),
        .load        (seed_load),
        .seed_in     (seed_in),
        .state       (lfsr_state),
        .period      (period),
        .period_wrap (period_wrap)
    );

    assign cand   = lfsr_state[OUT_W-1:0];
    assign accept = in_range(32'(cand), 32'(RANGE_MAX));
    assign take   = en && accept;
    assign hs     = (fsm_q == HOLD) && rng.rnd_ready;

    // Rejection FSM: capture a good candidate, reload on handshake.
    always_comb begin
        fsm_d   = fsm_q;
        value_d = value_q;
        if (seed_load) begin
            fsm_d = FILL;
        end else begin
            unique case (fsm_q)
                FILL: begin
                    if (take) begin
                        value_d = cand;
                        fsm_d   = HOLD;
                    end
                end
                HOLD: begin
                    if (hs) begin
                        if (take) begin
                            value_d = cand;
                        end else begin
                            fsm_d = FILL;
                        end
                    end
                end
            endcase
        end
    end

    // FSM and sample registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= FILL;
            value_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            value_q <= value_d;
        end
    end

    assign rng.rnd_valid = (fsm_q == HOLD);
    assign rng.rnd_value = value_q;

endmodule

// File: tb/tb_lfsr_rng_ranged.sv
// Directed bench for lfsr_rng_ranged: 8-bit default instance plus
// a 16-bit instance exercised over its full period.
module tb_lfsr_rng_ranged;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en;
    logic       seed_load;
    logic [7:0] seed_in;
    logic [7:0] lfsr_state;
    logic [7:0] period;
    logic       period_wrap;

    lfsr_rng_if #(.OUT_W(4)) bus ();

    lfsr_rng_ranged dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .seed_load   (seed_load),
        .seed_in     (seed_in),
        .rng         (bus),
        .lfsr_state  (lfsr_state),
        .period      (period),
        .period_wrap (period_wrap)
    );

    logic        r16;
    logic        en16;
    logic        ld16;
    logic [15:0] seed16;
    logic [15:0] state16;
    logic [15:0] period16;
    logic        wrap16;

    lfsr_rng_if #(.OUT_W(4)) bus16 ();

    lfsr_rng_ranged #(
        .WIDTH     (16),
        .TAPS      (16'hB400),
        .SEED      (16'hACE1),
        .OUT_W     (4),
        .RANGE_MAX (9)
    ) dut16 (
        .clk         (clk),
        .reset       (r16),
        .en          (en16),
        .seed_load   (ld16),
        .seed_in     (seed16),
        .rng         (bus16),
        .lfsr_state  (state16),
        .period      (period16),
        .period_wrap (wrap16)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] st8(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    logic [7:0] m;
    logic [3:0] cand;
    logic       acc;
    int         hs;
    int         cyc;
    logic       seen [256];
    int         dup;
    int         zero;
    int         wraps;
    int         bad16;
    int         n16;

    initial begin
        reset = 1'b1; en = 1'b0; seed_load = 1'b0; seed_in = 8'h00;
        bus.rnd_ready = 1'b0;
        r16 = 1'b1; en16 = 1'b0; ld16 = 1'b0; seed16 = 16'h0000;
        bus16.rnd_ready = 1'b0;

        // reset state
        tick();
        reset = 1'b0;
        chk("rst_state", lfsr_state, 8'hAC);
        chk("rst_period", period, 0);
        chk("rst_wrap", period_wrap, 0);
        chk("rst_valid", bus.rnd_valid, 0);
        chk("rst_value", bus.rnd_value, 0);

        // first candidate 12 rejected, then 9 accepted
        en = 1'b1;
        tick();
        chk("c1_state", lfsr_state, 8'h59);
        chk("c1_valid", bus.rnd_valid, 0);
        chk("c1_period", period, 1);
        tick();
        chk("c2_valid", bus.rnd_valid, 1);
        chk("c2_value", bus.rnd_value, 9);
        chk("c2_state", lfsr_state, 8'hB2);

        // hold while ready low
        en = 1'b0;
        tick();
        tick();
        chk("hold_value", bus.rnd_value, 9);
        chk("hold_valid", bus.rnd_valid, 1);
        chk("hold_state", lfsr_state, 8'hB2);

        // back-to-back handshakes
        en = 1'b1; bus.rnd_ready = 1'b1;
        tick();
        chk("b2b_value0", bus.rnd_value, 2);
        chk("b2b_valid0", bus.rnd_valid, 1);
        chk("b2b_state0", lfsr_state, 8'h65);
        tick();
        chk("b2b_value1", bus.rnd_value, 5);
        chk("b2b_valid1", bus.rnd_valid, 1);
        tick();
        chk("b2b_drop_valid", bus.rnd_valid, 0);
        chk("b2b_drop_state", lfsr_state, 8'h96);

        // stream against a bench model
        m = 8'h96; hs = 0; cyc = 0;
        while (hs < 200 && cyc < 2000) begin
            cand = m[3:0];
            acc  = (cand >= 4'd1) && (cand <= 4'd9);
            if (bus.rnd_valid) hs++;
            tick();
            cyc++;
            m = st8(m);
            chk("stream_state", lfsr_state, m);
            chk("stream_valid", bus.rnd_valid, acc);
            if (acc) chk("stream_value", bus.rnd_value, cand);
        end
        chk("stream_count", (hs >= 200), 1);

        // full period from reset
        reset = 1'b1; en = 1'b0; bus.rnd_ready = 1'b0;
        tick();
        reset = 1'b0; en = 1'b1;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[8'hAC] = 1'b1;
        dup = 0; zero = 0; wraps = 0;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (period_wrap) wraps++;
            if (i < 255) begin
                if (lfsr_state == 8'h00) zero++;
                if (seen[lfsr_state]) dup++;
                seen[lfsr_state] = 1'b1;
            end
            if (i == 254) chk("period_254", period, 254);
        end
        chk("per_wraps", wraps, 1);
        chk("per_wrap_now", period_wrap, 1);
        chk("per_period", period, 0);
        chk("per_state", lfsr_state, 8'hAC);
        chk("per_dup", dup, 0);
        chk("per_zero", zero, 0);
        en = 1'b0;
        tick();
        chk("per_wrap_clear", period_wrap, 0);

        // seed load while in HOLD
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b1;
        tick();
        tick();
        chk("sl_pre_valid", bus.rnd_valid, 1);
        seed_load = 1'b1; seed_in = 8'h00;
        tick();
        chk("sl0_state", lfsr_state, 8'hAC);
        chk("sl0_period", period, 0);
        chk("sl0_valid", bus.rnd_valid, 0);
        seed_in = 8'h01;
        tick();
        chk("sl1_state", lfsr_state, 8'h01);
        seed_load = 1'b0;

        // en low holds everything in FILL
        en = 1'b0;
        repeat (5) tick();
        chk("en0_state", lfsr_state, 8'h01);
        chk("en0_period", period, 0);
        chk("en0_valid", bus.rnd_valid, 0);
        en = 1'b1;
        tick();
        chk("en1_valid", bus.rnd_valid, 1);
        chk("en1_value", bus.rnd_value, 1);
        chk("en1_state", lfsr_state, 8'h02);
        en = 1'b0; bus.rnd_ready = 1'b1;
        tick();
        chk("hs_en0_valid", bus.rnd_valid, 0);
        chk("hs_en0_state", lfsr_state, 8'h02);
        chk("hs_en0_period", period, 1);
        en = 1'b1; bus.rnd_ready = 1'b0;
        tick();
        chk("refill_valid", bus.rnd_valid, 1);
        chk("refill_value", bus.rnd_value, 2);
        chk("refill_state", lfsr_state, 8'h04);

        // reset mid-handshake
        bus.rnd_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b0; bus.rnd_ready = 1'b0;
        chk("rmid_valid", bus.rnd_valid, 0);
        chk("rmid_value", bus.rnd_value, 0);
        chk("rmid_state", lfsr_state, 8'hAC);

        // 16-bit instance over a full period
        tick();
        r16 = 1'b0; en16 = 1'b1; bus16.rnd_ready = 1'b1;
        wraps = 0; bad16 = 0; n16 = 0;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            if (wrap16) wraps++;
            if (bus16.rnd_valid) begin
                n16++;
                if (bus16.rnd_value < 4'd1 || bus16.rnd_value > 4'd9) bad16++;
            end
        end
        chk("w16_wraps", wraps, 1);
        chk("w16_wrap_now", wrap16, 1);
        chk("w16_period", period16, 0);
        chk("w16_state", state16, 16'hACE1);
        chk("w16_range", bad16, 0);
        chk("w16_samples", (n16 > 1000), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lfsr_rng_ranged.md
Name: lfsr_rng_ranged

Overview:
Parametrised Fibonacci LFSR random source for the Sudoku datapath. It generalises the fixed 8-bit generator in three ways: configurable width and taps, runtime seed load with zero-seed protection, and a period counter with a wrap pulse. Its main output is a range-limited value (1..RANGE_MAX, default 1..9 for cell digits), produced by rejection sampling and delivered on a valid/ready handshake to the puzzle-generation FSM.

Parameters:
WIDTH, 8, LFSR state width (3..32)
TAPS, 8'hB8, feedback tap mask over state bits (default x^8+x^6+x^5+x^4+1); must be maximal-length
SEED, 8'hAC, reset seed and substitute for a zero seed_in; must be nonzero
OUT_W, 4, width of candidate/result (OUT_W <= WIDTH)
RANGE_MAX, 9, largest accepted value (1..2^OUT_W-1)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  step enable; LFSR advances one step per cycle when high
seed_load  input  1  load seed_in on this edge; takes priority over en
seed_in  input  WIDTH  seed value; zero is replaced by SEED
rnd_ready  input  1  consumer accepts rnd_value when rnd_valid & rnd_ready
rnd_valid  output  1  rnd_value holds an accepted sample
rnd_value  output  OUT_W  accepted sample, 1..RANGE_MAX
lfsr_state  output  WIDTH  current LFSR register
period  output  WIDTH  steps since reset/seed_load, modulo 2^WIDTH-1
period_wrap  output  1  one-cycle pulse on the step that returns period to 0

Behaviour:
- Reset (reset=1 at edge): lfsr_state=SEED, period=0, period_wrap=0, rnd_valid=0, rnd_value=0, FSM=FILL. All outputs are registered.
- Step: next = {state[WIDTH-2:0], ^(state & TAPS)}.
- seed_load=1: state = (seed_in==0 ? SEED : seed_in), period=0, period_wrap=0, rnd_valid=0, FSM=FILL. No step occurs that cycle, and any pending handshake is dropped.
- en=0: state, period and FSM all hold. A handshake still completes in HOLD (HOLD goes to FILL).
- Period: increments on each step. On the step where period==2^WIDTH-2, period becomes 0 and period_wrap=1 for the next cycle. At that point lfsr_state equals the loaded seed.
- Candidate = lfsr_state[OUT_W-1:0], taken from the pre-step registered state. Accept iff 1 <= candidate <= RANGE_MAX.
- FSM FILL (rnd_valid=0): on a cycle with en=1 and an acceptable candidate, rnd_value <= candidate and the FSM goes to HOLD. Otherwise it stays in FILL.
- FSM HOLD (rnd_valid=1): rnd_value is stable while rnd_ready=0.
  - On handshake with en=1 and an acceptable candidate: rnd_value reloads and the FSM stays in HOLD, giving back-to-back throughput.
  - On handshake otherwise: the FSM goes to FILL.
- Latency: one cycle from an accepted candidate to rnd_valid.
- Zero state is unreachable: seeds are nonzero and taps are maximal-length.
- Reset mid-handshake: the sample is discarded and no handshake is reported.

Decomposition:
- Package lfsr_rng_pkg: FSM state enum (FILL, HOLD), default tap constants per width (8'hB8, 16'hB400, 32'h80200003), and the function in_range(candidate, max).
- Sub-module lfsr_core (WIDTH, TAPS, SEED): state register, step, seed load with zero substitution, period counter and wrap pulse. The rejection FSM and handshake live in the top.

Test Plan:
- Reset then en=1, rnd_ready=0 -> state 0xAC (cand 12, reject). Next cycle state 0x59 (cand 9, accept). Cycle after that: rnd_valid=1, rnd_value=9, state 0xB2. Value holds while ready=0.
- Back-to-back: from HOLD(9), assert ready with state 0xB2 -> rnd_value=2, valid stays 1. Stream 200 handshakes -> every value is in 1..9 and no valid drops on acceptable candidates.
- Period: en=1 for 255 steps after reset -> period_wrap pulses exactly once, period=0, lfsr_state=0xAC. All 255 states are distinct and nonzero.
- seed_load with seed_in=0 while en=1 and in HOLD -> state=0xAC, period=0, rnd_valid=0 next cycle, no step that cycle. seed_in=0x01 -> state=0x01.
- en toggling: en=0 for 5 cycles in FILL -> state, period and valid unchanged. Handshake with en=0 in HOLD -> valid=0, FSM=FILL.
- Parameter sweep WIDTH=16, TAPS=16'hB400, SEED=16'hACE1, RANGE_MAX=9 -> 65535-step period with one wrap pulse; all rnd_value samples fall in 1..9.
